// File: rtl/res_pack_pkg.sv
// Shared geometry, derived widths and FSM encoding for the result-image packer.
// Image size, word format and the foreground threshold test.
package res_pack_pkg;

  localparam int IMG_W        = 128;
  localparam int PIX_N        = IMG_W * IMG_W;
  localparam int PIX_PER_WORD = 16;
  localparam int WORD_N       = PIX_N / PIX_PER_WORD;

  localparam int ADDR_W  = $clog2(PIX_N);
  localparam int WADDR_W = $clog2(WORD_N);
  localparam int FILL_W  = $clog2(PIX_PER_WORD);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  function automatic logic is_fg(input logic [7:0] pix, input logic [7:0] thresh);
    return (pix > thresh);
  endfunction

endpackage

// File: rtl/res_pack_shifter.sv
// MSB-first 16-bit pixel shift register with fill count; flags the shift that
// completes a word and presents the completed word combinationally.
module res_pack_shifter
  import res_pack_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    shift_en,
  input  logic                    bit_in,
  output logic [PIX_PER_WORD-1:0] word_next,
  output logic                    word_done
);

  logic [PIX_PER_WORD-1:0] shift_r;
  logic [FILL_W-1:0]       fill_r;

  // Shift register and fill count; a new run clears any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= {PIX_PER_WORD{1'b0}};
      fill_r  <= {FILL_W{1'b0}};
    end else if (clear) begin
      shift_r <= {PIX_PER_WORD{1'b0}};
      fill_r  <= {FILL_W{1'b0}};
    end else if (shift_en) begin
      shift_r <= {shift_r[PIX_PER_WORD-2:0], bit_in};
      fill_r  <= fill_r + FILL_W'(1);
    end else begin
      shift_r <= shift_r;
      fill_r  <= fill_r;
    end
  end

  // The word including the incoming bit, valid on the sixteenth shift.
  always_comb begin
    word_next = {shift_r[PIX_PER_WORD-2:0], bit_in};
    word_done = shift_en && (fill_r == FILL_W'(PIX_PER_WORD - 1));
  end

endmodule

// File: rtl/res_pack.sv
// Streams the 128x128 distance map out of the result RAM, thresholds each pixel
// and writes 16-pixel packed words (leftmost pixel in the MSB) to the packed RAM.
module res_pack
  import res_pack_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    res_rd,
  output logic [ADDR_W-1:0]       res_addr,
  input  logic [7:0]              res_di,
  output logic                    pk_wr,
  output logic [WADDR_W-1:0]      pk_addr,
  output logic [PIX_PER_WORD-1:0] pk_do
);

  state_t                  state_r;
  state_t                  state_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    rd_s;
  logic                    accept_s;
  logic [ADDR_W-1:0]       addr_s;
  logic [ADDR_W-1:0]       pix_r;
  logic                    pix_bit_s;
  logic                    word_done_s;
  logic                    word_wr_s;
  logic [PIX_PER_WORD-1:0] word_next_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (res_addr == LAST_PIX) state_s = DRAIN;
        else                      state_s = RUN;
      end
      DRAIN:   state_s = FIN;
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered controls and read address.
  always_comb begin
    busy_s   = (state_s == RUN) || (state_s == DRAIN);
    done_s   = (state_s == FIN);
    rd_s     = (state_s == RUN);
    accept_s = (state_r == IDLE) && start;
    addr_s   = res_addr;
    case (state_r)
      IDLE: begin
        if (start) addr_s = {ADDR_W{1'b0}};
        else       addr_s = res_addr;
      end
      RUN: begin
        if (res_addr != LAST_PIX) addr_s = res_addr + ADDR_W'(1);
        else                      addr_s = res_addr;
      end
      default: addr_s = res_addr;
    endcase
  end

  // Registered control outputs and result-RAM address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      res_rd   <= 1'b0;
      res_addr <= {ADDR_W{1'b0}};
    end else begin
      busy     <= busy_s;
      done     <= done_s;
      res_rd   <= rd_s;
      res_addr <= addr_s;
    end
  end

  // A read issued last cycle returns data now, so res_rd doubles as sample-valid.
  always_comb begin
    pix_bit_s = is_fg(res_di, THRESH);
    word_wr_s = word_done_s && (pix_r[FILL_W-1:0] == FILL_W'(PIX_PER_WORD - 1));
  end

  res_pack_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_s),
    .shift_en  (res_rd),
    .bit_in    (pix_bit_s),
    .word_next (word_next_s),
    .word_done (word_done_s)
  );

  // Count of pixels sampled in this run; its upper bits are the word address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      pix_r <= {ADDR_W{1'b0}};
    end else if (res_rd) begin
      pix_r <= pix_r + ADDR_W'(1);
    end else begin
      pix_r <= pix_r;
    end
  end

  // Packed-RAM write port; address and data hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pk_wr   <= 1'b0;
      pk_addr <= {WADDR_W{1'b0}};
      pk_do   <= {PIX_PER_WORD{1'b0}};
    end else if (word_wr_s) begin
      pk_wr   <= 1'b1;
      pk_addr <= pix_r[ADDR_W-1:FILL_W];
      pk_do   <= word_next_s;
    end else begin
      pk_wr   <= 1'b0;
      pk_addr <= pk_addr;
      pk_do   <= pk_do;
    end
  end

endmodule

// File: tb/tb_res_pack.sv
// Bench for res_pack: two instances (THRESH 0 and 3) read one shared image model;
// expected packed words are queued at start and popped as pk_wr strobes appear.
module tb_res_pack;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy_a  [2];
  logic        done_a  [2];
  logic        rd_a    [2];
  logic [13:0] raddr_a [2];
  logic [7:0]  rdi_a   [2];
  logic        wr_a    [2];
  logic [9:0]  paddr_a [2];
  logic [15:0] pdo_a   [2];

  logic [7:0]  mem [0:16383];
  logic [15:0] cap [2][1024];
  exp_t        sb0 [$];
  exp_t        sb1 [$];
  int          total = 0;
  int          bad   = 0;

  res_pack #(.THRESH(8'd0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a[0]), .done(done_a[0]),
    .res_rd(rd_a[0]), .res_addr(raddr_a[0]), .res_di(rdi_a[0]),
    .pk_wr(wr_a[0]), .pk_addr(paddr_a[0]), .pk_do(pdo_a[0])
  );

  res_pack #(.THRESH(8'd3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a[1]), .done(done_a[1]),
    .res_rd(rd_a[1]), .res_addr(raddr_a[1]), .res_di(rdi_a[1]),
    .pk_wr(wr_a[1]), .pk_addr(paddr_a[1]), .pk_do(pdo_a[1])
  );

  always #5 clk = ~clk;

  // Result RAM model: read data latched on the falling edge
  always @(negedge clk) begin
    if (rd_a[0]) rdi_a[0] <= mem[raddr_a[0]];
    if (rd_a[1]) rdi_a[1] <= mem[raddr_a[1]];
  end

  function automatic logic [15:0] model_word(input int w, input logic [7:0] thr);
    logic [15:0] r;
    r = 16'h0000;
    for (int k = 0; k < 16; k++) r[15-k] = (mem[16*w+k] > thr);
    return r;
  endfunction

  task automatic load_sb();
    sb0.delete();
    sb1.delete();
    for (int w = 0; w < 1024; w++) begin
      sb0.push_back({10'(w), model_word(w, 8'd0)});
      sb1.push_back({10'(w), model_word(w, 8'd3)});
      cap[0][w] = 16'hxxxx;
      cap[1][w] = 16'hxxxx;
    end
  endtask

  // One run from start; k counts cycles after the accepting edge s
  task automatic run_image(input int abort_at, input bit spam);
    int   writes [2];
    int   dones  [2];
    int   busy_err [2];
    bit   have;
    exp_t e;
    for (int d = 0; d < 2; d++) begin writes[d] = 0; dones[d] = 0; busy_err[d] = 0; end
    load_sb();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (busy_a[d] !== 1'b1 || rd_a[d] !== 1'b1 || raddr_a[d] !== 14'd0) begin
        bad++;
        $display("FAIL start_accept dut%0d busy=%b rd=%b addr=%0d expected 1 1 0", d, busy_a[d], rd_a[d], raddr_a[d]);
      end
    end
    for (int k = 0; k <= 16392; k++) begin
      if (k > 0) @(negedge clk);
      start = (spam && (k == 4 || k == 15999)) ? 1'b1 : 1'b0;
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
          total++;
          if ({busy_a[d], done_a[d], rd_a[d], wr_a[d]} !== 4'b0000 || raddr_a[d] !== 14'd0 ||
              paddr_a[d] !== 10'd0 || pdo_a[d] !== 16'h0000) begin
            bad++;
            $display("FAIL abort_clear dut%0d busy=%b done=%b rd=%b wr=%b raddr=%0d paddr=%0d pdo=%h expected all 0",
                     d, busy_a[d], done_a[d], rd_a[d], wr_a[d], raddr_a[d], paddr_a[d], pdo_a[d]);
          end
        end
        repeat (3) begin
          @(negedge clk);
          for (int d = 0; d < 2; d++) begin
            total++;
            if (wr_a[d] !== 1'b0) begin
              bad++;
              $display("FAIL abort_no_write dut%0d pk_wr=%b expected 0", d, wr_a[d]);
            end
          end
        end
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
        return;
      end
      for (int d = 0; d < 2; d++) begin
        if (wr_a[d] === 1'b1) begin
          writes[d]++;
          total++;
          have = 1'b0;
          if (d == 0) begin
            if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
          end else begin
            if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
          end
          if (!have) begin
            bad++;
            $display("FAIL extra_write dut%0d addr=%0d data=%h k=%0d expected no write", d, paddr_a[d], pdo_a[d], k);
          end else begin
            cap[d][paddr_a[d]] = pdo_a[d];
            if (paddr_a[d] !== e.addr || pdo_a[d] !== e.data || k != 16*int'(e.addr)+16) begin
              bad++;
              $display("FAIL word dut%0d addr=%0d data=%h k=%0d expected addr=%0d data=%h k=%0d",
                       d, paddr_a[d], pdo_a[d], k, e.addr, e.data, 16*int'(e.addr)+16);
            end
          end
        end
        if (done_a[d] === 1'b1) begin
          dones[d]++;
          total++;
          if (k != 16385 || busy_a[d] !== 1'b0) begin
            bad++;
            $display("FAIL done_timing dut%0d k=%0d busy=%b expected k=16385 busy=0", d, k, busy_a[d]);
          end
        end
        if (busy_a[d] !== (k < 16385)) busy_err[d]++;
        if (k == 16383 || k == 16384) begin
          total++;
          if (raddr_a[d] !== 14'd16383 || rd_a[d] !== (k == 16383)) begin
            bad++;
            $display("FAIL addr_end dut%0d k=%0d addr=%0d rd=%b expected addr=16383 rd=%b",
                     d, k, raddr_a[d], rd_a[d], (k == 16383));
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (writes[d] != 1024 || dones[d] != 1 || busy_err[d] != 0) begin
        bad++;
        $display("FAIL run_counts dut%0d writes=%0d dones=%0d busy_err=%0d expected 1024 1 0",
                 d, writes[d], dones[d], busy_err[d]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({busy_a[d], done_a[d], rd_a[d], wr_a[d]} !== 4'b0000 || raddr_a[d] !== 14'd0 ||
          paddr_a[d] !== 10'd0 || pdo_a[d] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_state dut%0d busy=%b done=%b rd=%b wr=%b raddr=%0d paddr=%0d pdo=%h expected all 0",
                 d, busy_a[d], done_a[d], rd_a[d], wr_a[d], raddr_a[d], paddr_a[d], pdo_a[d]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_all_zero_with_restarts();
    int nz;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    run_image(-1, 1'b1);
    nz = 0;
    for (int w = 0; w < 1024; w++) if (cap[0][w] !== 16'h0000) nz++;
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL all_zero nonzero_words=%0d expected 0", nz);
    end
  endtask

  task automatic test_edge_pixels();
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[0]     = 8'h05;
    mem[16383] = 8'h01;
    run_image(-1, 1'b0);
    total++;
    if (cap[0][0] !== 16'h8000) begin
      bad++; $display("FAIL first_pixel got=%h expected=8000", cap[0][0]);
    end
    total++;
    if (cap[0][1023] !== 16'h0001) begin
      bad++; $display("FAIL last_pixel got=%h expected=0001", cap[0][1023]);
    end
    total++;
    if (cap[1][1023] !== 16'h0000 || cap[1][0] !== 16'h8000) begin
      bad++; $display("FAIL thresh3_edges w0=%h w1023=%h expected 8000 0000", cap[1][0], cap[1][1023]);
    end
  endtask

  task automatic test_abort_restart();
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_image(100, 1'b0);
    run_image(-1, 1'b0);
    total++;
    if (cap[1][0] !== 16'h0FFF) begin
      bad++; $display("FAIL ramp_thresh3 got=%h expected=0fff", cap[1][0]);
    end
    total++;
    if (cap[0][0] !== 16'h7FFF) begin
      bad++; $display("FAIL ramp_thresh0 got=%h expected=7fff", cap[0][0]);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero_with_restarts();
    test_edge_pixels();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
